// File: rtl/axi_store_unit.sv
// axi_store_unit: single-outstanding AXI4-Lite store unit that formats byte lanes for a 64-bit bus.
// Define STORE_MISALIGN_SPLIT_EN to split stores crossing an 8-byte word into two writes.
module axi_store_unit #(
    parameter int         XLEN     = 64,
    parameter logic [2:0] AXI_PROT = 3'b000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_data,
    input  logic [1:0]      req_size,
    output logic            resp_valid,
    output logic            resp_fault,
    output logic            resp_misaligned,
    output logic            awvalid,
    input  logic            awready,
    output logic [XLEN-1:0] awaddr,
    output logic [2:0]      awprot,
    output logic            wvalid,
    input  logic            wready,
    output logic [63:0]     wdata,
    output logic [7:0]      wstrb,
    input  logic            bvalid,
    output logic            bready,
    input  logic [1:0]      bresp
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_DATA,
        RESP,
`ifdef STORE_MISALIGN_SPLIT_EN
        DONE,
        SECOND
`else
        DONE
`endif
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        aw_hs;
    logic        w_hs;
    logic        aw_done;
    logic        w_done;
    logic        fault_q;
    logic        misaligned_q;
    logic        in_addr_phase;
    logic [7:0]  size_mask;
    logic [63:0] data_lo;
    logic [7:0]  strb_lo;
    logic        unused_bresp;

`ifdef STORE_MISALIGN_SPLIT_EN
    logic [63:0] data_q;
    logic [2:0]  off_q;
    logic [7:0]  mask_q;
    logic        second_q;
    logic [63:0] data_hi;
    logic [7:0]  strb_hi;
    logic        crosses;

    // Upper-word beat: the bytes shifted past lane 7 by the low-word formatting.
    assign data_hi = data_q >> (7'd64 - {1'b0, off_q, 3'b000});
    assign strb_hi = mask_q >> (4'd8 - {1'b0, off_q});
    assign crosses = |strb_hi;
`else
    logic        req_misaligned;

    always_comb begin
        case (req_size)
            2'd0:    req_misaligned = 1'b0;
            2'd1:    req_misaligned = req_addr[0];
            2'd2:    req_misaligned = |req_addr[1:0];
            default: req_misaligned = |req_addr[2:0];
        endcase
    end
`endif

    assign awprot       = AXI_PROT;
    assign unused_bresp = bresp[0];
    assign accept       = req_valid && req_ready;
    assign aw_hs        = awvalid && awready;
    assign w_hs         = wvalid && wready;

    always_comb begin
        case (req_size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign data_lo = 64'(req_data) << {req_addr[2:0], 3'b000};
    assign strb_lo = size_mask << req_addr[2:0];

`ifdef STORE_MISALIGN_SPLIT_EN
    assign in_addr_phase = (state == ADDR_DATA) || (state == SECOND);
`else
    assign in_addr_phase = (state == ADDR_DATA);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = ADDR_DATA;
`ifndef STORE_MISALIGN_SPLIT_EN
                    if (req_misaligned) next_state = DONE;
`endif
                end
            end
            ADDR_DATA: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) next_state = RESP;
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            SECOND: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) next_state = RESP;
            end
`endif
            RESP: begin
                if (bvalid) begin
                    next_state = DONE;
`ifdef STORE_MISALIGN_SPLIT_EN
                    // A failed low beat ends the request without touching the upper word.
                    if (!second_q && crosses && !bresp[1]) next_state = SECOND;
`endif
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready       = (state == IDLE);
        awvalid         = in_addr_phase && !aw_done;
        wvalid          = in_addr_phase && !w_done;
        bready          = (state == RESP);
        resp_valid      = (state == DONE);
        resp_fault      = (state == DONE) && fault_q;
        resp_misaligned = (state == DONE) && misaligned_q;
    end

    // Payload registers hold steady for the whole address phase; handshake flags let AW and W retire independently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            awaddr       <= '0;
            wdata        <= '0;
            wstrb        <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            fault_q      <= 1'b0;
            misaligned_q <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
            data_q       <= '0;
            off_q        <= '0;
            mask_q       <= '0;
            second_q     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                awaddr  <= {req_addr[XLEN-1:3], 3'b000};
                wdata   <= data_lo;
                wstrb   <= strb_lo;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                fault_q <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
                misaligned_q <= 1'b0;
                data_q       <= 64'(req_data);
                off_q        <= req_addr[2:0];
                mask_q       <= size_mask;
                second_q     <= 1'b0;
`else
                misaligned_q <= req_misaligned;
`endif
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            if (bvalid && bready) begin
                fault_q <= bresp[1];
                aw_done <= 1'b0;
                w_done  <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
                if (next_state == SECOND) begin
                    awaddr   <= awaddr + XLEN'(8);
                    wdata    <= data_hi;
                    wstrb    <= strb_hi;
                    second_q <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: doc/axi_store_unit.md
AXI_STORE_UNIT -- requirements
Module: axi_store_unit

Interface
REQ-001 SHALL have parameter AXI_PROT, default 3'b000, the constant value driven on awprot.
REQ-002 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid in 1, req_ready out 1: store request handshake.
REQ-005 SHALL have ports req_addr in XLEN (byte address), req_data in XLEN (store data, LSB-justified), req_size in 2 (0 byte, 1 half, 2 word, 3 double).
REQ-006 SHALL have ports resp_valid out 1 (one-cycle completion pulse), resp_fault out 1 (bus error), resp_misaligned out 1 (alignment fault).
REQ-007 SHALL have AXI4-Lite write master ports: awvalid out 1, awready in 1, awaddr out XLEN, awprot out 3, wvalid out 1, wready in 1, wdata out 64, wstrb out 8, bvalid in 1, bready out 1, bresp in 2.

Function
REQ-008 SHALL implement states IDLE, ADDR_DATA, RESP, DONE, plus SECOND when STORE_MISALIGN_SPLIT_EN is defined.
REQ-009 SHALL drive req_ready=1 only in IDLE; a request is accepted on req_valid&req_ready, and all request fields are registered at acceptance.
REQ-010 Alignment rule: a request is misaligned when req_addr mod 2^req_size != 0.
REQ-011 Aligned request: IDLE->ADDR_DATA; awvalid and wvalid both rise the cycle after acceptance.
REQ-012 Address and data formatting: awaddr = {req_addr[XLEN-1:3],3'b000}; wdata = req_data << 8*req_addr[2:0], truncated to 64 bits; wstrb = ((1<<2^size)-1) << req_addr[2:0].
REQ-013 awvalid and wvalid SHALL each remain high, with payload stable, until their own handshake; each deasserts independently the cycle after its handshake.
REQ-014 Both handshakes done -> RESP; bready=1 only in RESP; bvalid arriving outside RESP SHALL be ignored.
REQ-015 bvalid&bready -> DONE; the DONE cycle SHALL drive resp_valid=1 and resp_fault=bresp[1], then return to IDLE.
REQ-016 Minimum latency with awready=wready=bvalid=1 constantly: acceptance at cycle 0, AW/W handshake cycle 1, B handshake cycle 2, resp_valid cycle 3.
REQ-017 resp_fault and resp_misaligned SHALL be 0 whenever resp_valid=0.

Reset
REQ-018 rst=0 SHALL immediately force state IDLE and awvalid, wvalid, bready, resp_valid, resp_fault, resp_misaligned to 0, and awaddr, wdata, wstrb to 0.
REQ-019 Reset mid-transaction SHALL abandon the transaction with no resp_valid pulse; req_ready=1 from the first clock edge after rst returns to 1.

Configuration
REQ-020 Without STORE_MISALIGN_SPLIT_EN: a misaligned request SHALL issue no AXI traffic; it goes IDLE->DONE with resp_valid=1, resp_misaligned=1, resp_fault=0 the cycle after acceptance.
REQ-021 With STORE_MISALIGN_SPLIT_EN, a misaligned store within one 8-byte word SHALL be issued as one transaction per REQ-012, with resp_misaligned=0.
REQ-022 With STORE_MISALIGN_SPLIT_EN, a store crossing an 8-byte boundary SHALL issue two transactions, low word first per REQ-012.
REQ-023 The second (SECOND) transaction SHALL use: awaddr = low awaddr+8; wdata = req_data >> 8*(8-req_addr[2:0]); wstrb = mask >> (8-req_addr[2:0]).
REQ-024 If the first transaction's bresp[1]=1, the second transaction SHALL be skipped and the unit SHALL report resp_fault=1.
REQ-025 When both transactions are issued, resp_fault SHALL equal the second transaction's bresp[1], and resp_valid SHALL pulse once per request.

Verification
REQ-026 SB addr 0x1003, data 0xAB, ready/bvalid=1 -> awaddr 0x1000, wstrb 0x08, wdata[31:24]=0xAB, resp_valid at cycle 3, resp_fault=0.
REQ-027 SD addr 0x2000, data 0x66778899_017F423C, wready delayed 3 cycles after awready -> awvalid drops after its handshake, wvalid held, bready only after W handshake, wstrb 0xFF, wdata matches data.
REQ-028 SW addr 0x3004 with bresp=2'b10 -> wstrb 0xF0, resp_fault=1, resp_misaligned=0.
REQ-029 Without macro: SH addr 0x1001 -> no awvalid, resp_misaligned=1 one cycle after acceptance. With macro: SH 0x1007, data 0xBEEF -> txn1 awaddr 0x1000, wstrb 0x80, wdata[63:56]=0xEF; txn2 awaddr 0x1008, wstrb 0x01, wdata[7:0]=0xBE.
REQ-030 rst=0 while in RESP -> bready, awvalid, wvalid, resp_valid low immediately, no resp pulse, req_ready=1 after release, next SB completes normally.
